alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
- Moore control unit that drives the phase-1 datapath control lines for the fetch cycle (T0-T2) and a three-register ALU instruction (T3-T5).
- Replaces the hand-timed strobe sequences in the datapath benches.
- Decodes IR into one-hot register enables and op_code.
- Stalls fetch on a memory-ready handshake.
- Counts retired instructions; latches a fault on illegal encodings.

Parameters:
- NUM_REGS, 16, width of Rin/Rout one-hot buses; register fields >= NUM_REGS are illegal.
- MAX_OPCODE, 12, highest legal ALU opcode (0..MAX_OPCODE execute via T3-T5).
- COUNT_W, 16, width of retired-instruction counter.

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  asynchronous, active-low reset.
- Run  in  1  level; start/continue fetching.
- Mem_ready  in  1  memory read data valid this cycle.
- IR  in  32  instruction register contents: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- PCout, ZLowout, ZHighout, MDRout  out  1 each  bus-drive selects.
- MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin  out  1 each  register load enables.
- Read, IncPC  out  1 each  memory read / ALU PC-increment mode.
- op_code  out  5  ALU operation.
- Rin  out  NUM_REGS  one-hot GPR load.
- Rout  out  NUM_REGS  one-hot GPR bus drive.
- Done  out  1  one-cycle pulse on instruction retire.
- Fault  out  1  sticky illegal-instruction flag.
- instr_count  out  COUNT_W  retired instruction count.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, FAULT.
- Outputs decode from the state register and IR only (Moore, no input paths except Mem_ready in T1). Every unlisted output is 0.
- Reset (Clear=0, asynchronous): state=IDLE, instr_count=0, Fault=0. All outputs 0 while Clear is low.
- IDLE: no strobes. Run=1 -> T0, else stay.
- T0: PCout, MARin, IncPC, ZLowIn. -> T1.
- T1: Read=1 every cycle.
  - Mem_ready=0: stay in T1 with only Read high.
  - Mem_ready=1: additionally ZLowout, PCin, MDRin, then -> T2. PC updates exactly once per fetch.
- T2: MDRout, IRin. -> T3.
- T3: legality check on IR. Illegal if opcode > MAX_OPCODE or any of Ra/Rb/Rc >= NUM_REGS.
  - Illegal: no strobes, -> FAULT.
  - Legal: Rout = 1<<Rb, Yin. -> T4.
- T4: Rout = 1<<Rc, op_code = IR[31:27], ZLowIn. -> T5.
- T5: ZLowout, Rin = 1<<Ra, Done=1; instr_count += 1, wrapping at 2^COUNT_W-1 -> 0. Then Run=1 -> T0, Run=0 -> IDLE.
- op_code is 0 in every state except T4 (and T5/T6 under the optional feature).
- Ra=Rb=Rc is legal; Rout and Rin each stay one-hot.
- Run deassert mid-instruction: the instruction completes; only the T5 exit checks Run.
- FAULT: Fault=1, no strobes, held until Clear. Run is ignored.
- Clear mid-instruction: abort immediately to IDLE; partial strobes are dropped.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined:
  - opcodes MAX_OPCODE+1 (mul) and MAX_OPCODE+2 (div) are legal.
  - T4 additionally asserts ZHighIn.
  - T5 asserts ZLowout and LOin; Rin=0 and Done=0.
  - New state T6 asserts ZHighout, HIin, Done, and increments the count, then exits exactly as T5 does.
- Undefined: T6 does not exist; ZHighout, ZHighIn, HIin and LOin are tied 0; those opcodes take FAULT.

Test Plan:
- Reset, Run=1, Mem_ready=1, IR=32'h28918000.
  - Required: T0..T5 in 6 cycles.
  - T3: Rout=16'h0004 (R2) with Yin.
  - T4: Rout=16'h0008 (R3), op_code=5'b00101, ZLowIn.
  - T5: Rin=16'h0002 (R1) with ZLowout, Done pulse; instr_count=1. Then T0.
- Mem_ready held 0 for 3 cycles in T1.
  - Required: Read high 4 cycles; PCin/MDRin/ZLowout high only on the Mem_ready=1 cycle.
  - Total latency 9 cycles.
- Run=1 for 3 instructions, then Run=0 during T3 of the third.
  - Required: third instruction retires; instr_count=3; state IDLE with all outputs 0.
- IR=32'hF8000000 (opcode 31).
  - Required: T3 drives no strobes; FAULT; Fault=1 persists with Run=1.
  - Clear pulse low -> Fault=0, IDLE.
- Clear asserted low during T4.
  - Required: same-time ZLowIn=0, Rout=0, op_code=0; instr_count=0.
- ALU_MULDIV_EN defined, opcode 13, Ra=1, Rb=2, Rc=3.
  - Required: T4 ZLowIn+ZHighIn; T5 LOin; T6 HIin with Done; Rin=0 throughout.
  - Undefined build: same IR -> FAULT.

Source files
------------

// File: rtl/alu_instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_instr_sequencer_if
//   Bundles the control-unit side of the phase-1 datapath: the sequencing
//   inputs (Run, Mem_ready, IR) and every control line the sequencer drives.
//
//   Modports:
//     master - the sequencer: receives Run/Mem_ready/IR, drives the strobes.
//     slave  - the datapath (or a bench): drives Run/Mem_ready/IR, receives
//              the strobes.
//
//   Parameters must match the sequencer instance bound to this interface:
//     NUM_REGS - width of the one-hot Rin/Rout buses.
//     COUNT_W  - width of the retired-instruction counter.
// ---------------------------------------------------------------------------
interface alu_instr_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int COUNT_W  = 16
);
    // Sequencing inputs
    logic                Run;
    logic                Mem_ready;
    logic [31:0]         IR;

    // Bus-drive selects
    logic                PCout;
    logic                ZLowout;
    logic                ZHighout;
    logic                MDRout;

    // Register load enables
    logic                MARin;
    logic                PCin;
    logic                MDRin;
    logic                IRin;
    logic                Yin;
    logic                ZLowIn;
    logic                ZHighIn;
    logic                HIin;
    logic                LOin;

    // Memory / ALU mode
    logic                Read;
    logic                IncPC;
    logic [4:0]          op_code;

    // General-purpose register file selects
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;

    // Status
    logic                Done;
    logic                Fault;
    logic [COUNT_W-1:0]  instr_count;

    modport master (
        input  Run, Mem_ready, IR,
        output PCout, ZLowout, ZHighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
        output Read, IncPC, op_code, Rin, Rout,
        output Done, Fault, instr_count
    );

    modport slave (
        output Run, Mem_ready, IR,
        input  PCout, ZLowout, ZHighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
        input  Read, IncPC, op_code, Rin, Rout,
        input  Done, Fault, instr_count
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// alu_instr_sequencer
//   Moore control unit for the phase-1 datapath. Sequences the fetch cycle
//   (T0-T2) followed by a three-register ALU instruction (T3-T5), decoding
//   IR into one-hot register selects and the ALU op_code. Fetch stalls in T1
//   until memory reports ready. Retired instructions are counted; an illegal
//   encoding parks the unit in FAULT until Clear.
//
//   Ports:
//     Clock - rising-edge clock.
//     Clear - asynchronous active-low reset.
//     bus   - alu_instr_sequencer_if.master: Run, Mem_ready, IR in; all
//             datapath strobes, op_code, Rin/Rout, Done, Fault, instr_count out.
//
//   IR layout: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
//
//   Configuration macro ALU_MULDIV_EN:
//     Defined   - opcodes MAX_OPCODE+1 (mul) and MAX_OPCODE+2 (div) are legal;
//                 they capture the 64-bit product/quotient via ZHigh/ZLow into
//                 HI/LO over T5 and an extra state T6.
//     Undefined - no T6; ZHighout, ZHighIn, HIin and LOin stay 0 and those
//                 opcodes fault.
// ---------------------------------------------------------------------------
module alu_instr_sequencer #(
    parameter int NUM_REGS   = 16,
    parameter int MAX_OPCODE = 12,
    parameter int COUNT_W    = 16
) (
    input  logic                   Clock,
    input  logic                   Clear,
    alu_instr_sequencer_if.master  bus
);

`ifdef ALU_MULDIV_EN
    localparam int LAST_LEGAL_OPCODE = MAX_OPCODE + 2;
`else
    localparam int LAST_LEGAL_OPCODE = MAX_OPCODE;
`endif

    localparam logic [NUM_REGS-1:0] REG_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_FAULT
`ifdef ALU_MULDIV_EN
        , S_T6
`endif
    } state_t;

    state_t             state;
    logic [COUNT_W-1:0] count_q;

    // Instruction field decode
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       legal;
    logic       unused_ir;

    assign opcode = bus.IR[31:27];
    assign ra     = bus.IR[26:23];
    assign rb     = bus.IR[22:19];
    assign rc     = bus.IR[18:15];
    assign unused_ir = ^bus.IR[14:0];

    assign legal = (int'(opcode) <= LAST_LEGAL_OPCODE) &&
                   (int'(ra) < NUM_REGS) &&
                   (int'(rb) < NUM_REGS) &&
                   (int'(rc) < NUM_REGS);

`ifdef ALU_MULDIV_EN
    logic is_muldiv;
    assign is_muldiv = int'(opcode) > MAX_OPCODE;
`endif

    // ------------------------------------------------------------------
    // State and retire counter
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state   <= S_IDLE;
            count_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.Run) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   if (bus.Mem_ready) state <= S_T2;
                S_T2:   state <= S_T3;
                S_T3:   state <= legal ? S_T4 : S_FAULT;
                S_T4:   state <= S_T5;
`ifdef ALU_MULDIV_EN
                S_T5: begin
                    if (is_muldiv) begin
                        state <= S_T6;
                    end else begin
                        count_q <= count_q + 1'b1;
                        state   <= bus.Run ? S_T0 : S_IDLE;
                    end
                end
                S_T6: begin
                    count_q <= count_q + 1'b1;
                    state   <= bus.Run ? S_T0 : S_IDLE;
                end
`else
                S_T5: begin
                    count_q <= count_q + 1'b1;
                    state   <= bus.Run ? S_T0 : S_IDLE;
                end
`endif
                S_FAULT: state <= S_FAULT;   // sticky until Clear
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_count = count_q;

    // ------------------------------------------------------------------
    // Output decode: state + IR only, with Mem_ready qualifying T1 strobes.
    // Because state resets asynchronously, every strobe drops the moment
    // Clear goes low.
    // ------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        bus.PCout    = 1'b0;
        bus.ZLowout  = 1'b0;
        bus.ZHighout = 1'b0;
        bus.MDRout   = 1'b0;
        bus.MARin    = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.ZLowIn   = 1'b0;
        bus.ZHighIn  = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Read     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.op_code  = 5'd0;
        bus.Rin      = '0;
        bus.Rout     = '0;
        bus.Done     = 1'b0;
        bus.Fault    = 1'b0;

        case (state)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.ZLowIn = 1'b1;
            end
            S_T1: begin
                bus.Read = 1'b1;
                // PC, MDR and the bus transfer happen only on the ready cycle,
                // so a stalled fetch updates PC exactly once.
                if (bus.Mem_ready) begin
                    bus.ZLowout = 1'b1;
                    bus.PCin    = 1'b1;
                    bus.MDRin   = 1'b1;
                end
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (legal) begin
                    bus.Rout = REG_ONE << rb;
                    bus.Yin  = 1'b1;
                end
            end
            S_T4: begin
                bus.Rout    = REG_ONE << rc;
                bus.op_code = opcode;
                bus.ZLowIn  = 1'b1;
`ifdef ALU_MULDIV_EN
                bus.ZHighIn = is_muldiv;
`endif
            end
            S_T5: begin
                bus.ZLowout = 1'b1;
`ifdef ALU_MULDIV_EN
                if (is_muldiv) begin
                    bus.LOin    = 1'b1;
                    bus.op_code = opcode;
                end else begin
                    bus.Rin  = REG_ONE << ra;
                    bus.Done = 1'b1;
                end
`else
                bus.Rin  = REG_ONE << ra;
                bus.Done = 1'b1;
`endif
            end
`ifdef ALU_MULDIV_EN
            S_T6: begin
                bus.ZHighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.op_code  = opcode;
                bus.Done     = 1'b1;
            end
`endif
            S_FAULT: bus.Fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_instr_sequencer
//   Self-checking bench for alu_instr_sequencer. Inputs are driven just
//   after the falling edge and outputs are sampled 1 time unit later, so the
//   combinational Mem_ready path in T1 is observed with its current input.
//   Expected behaviour comes from a per-instruction cycle plan built from
//   the instruction's fields (fetch, optional stall cycles, operand reads,
//   ALU step, write-back) rather than from any state encoding.
// ---------------------------------------------------------------------------
module tb_alu_instr_sequencer;

    localparam int NUM_REGS   = 16;
    localparam int MAX_OPCODE = 12;
    localparam int COUNT_W    = 16;
`ifdef ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Clear;
    always #5 Clock = ~Clock;

    alu_instr_sequencer_if #(.NUM_REGS(NUM_REGS), .COUNT_W(COUNT_W)) bus ();

    alu_instr_sequencer #(
        .NUM_REGS  (NUM_REGS),
        .MAX_OPCODE(MAX_OPCODE),
        .COUNT_W   (COUNT_W)
    ) dut (
        .Clock(Clock),
        .Clear(Clear),
        .bus  (bus)
    );

    typedef struct packed {
        logic                pc_out, zlow_out, zhigh_out, mdr_out;
        logic                mar_in, pc_in, mdr_in, ir_in, y_in;
        logic                zlow_in, zhigh_in, hi_in, lo_in;
        logic                read, inc_pc;
        logic [4:0]          op;
        logic [NUM_REGS-1:0] rin, rout;
        logic                done, fault;
        logic [COUNT_W-1:0]  count;
    } outs_t;

    typedef struct {
        logic        run;
        logic        mem_ready;
        logic [31:0] ir;
        outs_t       exp;
        string       name;
    } vec_t;

    typedef struct {
        logic  mem_ready;
        bit    use_ir;
        outs_t exp;
        string name;
    } step_t;

    int                 errors = 0;
    int                 checks = 0;
    logic [COUNT_W-1:0] model_count;
    bit                 in_idle;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic outs_t sample();
        outs_t s;
        s.pc_out    = bus.PCout;
        s.zlow_out  = bus.ZLowout;
        s.zhigh_out = bus.ZHighout;
        s.mdr_out   = bus.MDRout;
        s.mar_in    = bus.MARin;
        s.pc_in     = bus.PCin;
        s.mdr_in    = bus.MDRin;
        s.ir_in     = bus.IRin;
        s.y_in      = bus.Yin;
        s.zlow_in   = bus.ZLowIn;
        s.zhigh_in  = bus.ZHighIn;
        s.hi_in     = bus.HIin;
        s.lo_in     = bus.LOin;
        s.read      = bus.Read;
        s.inc_pc    = bus.IncPC;
        s.op        = bus.op_code;
        s.rin       = bus.Rin;
        s.rout      = bus.Rout;
        s.done      = bus.Done;
        s.fault     = bus.Fault;
        s.count     = bus.instr_count;
        return s;
    endfunction

    function automatic outs_t quiet();
        outs_t e;
        e       = '0;
        e.count = model_count;
        return e;
    endfunction

    function automatic logic [NUM_REGS-1:0] reg_sel(input int idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic bit ir_legal(input logic [31:0] ir);
        int last;
        last = MAX_OPCODE + (MULDIV ? 2 : 0);
        return (int'(ir[31:27]) <= last) && (int'(ir[26:23]) < NUM_REGS) &&
               (int'(ir[22:19]) < NUM_REGS) && (int'(ir[18:15]) < NUM_REGS);
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic apply(input logic run, input logic mr, input logic [31:0] ir,
                         input outs_t exp, input string name);
        @(negedge Clock);
        bus.Run       = run;
        bus.Mem_ready = mr;
        bus.IR        = ir;
        #1;
        check(name, sample(), exp);
    endtask

    task automatic clear_pulse(input string name);
        @(negedge Clock);
        bus.Run = 1'b0;
        Clear   = 1'b0;
        #1;
        model_count = '0;
        check(name, sample(), quiet());
        #1;
        Clear   = 1'b1;
        in_idle = 1'b1;
    endtask

    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++)
            apply(1'b0, 1'($urandom), $urandom, quiet(), "idle_hold");
    endtask

    task automatic fault_hold(input int n);
        outs_t e;
        e       = quiet();
        e.fault = 1'b1;
        for (int i = 0; i < n; i++)
            apply(1'b1, 1'($urandom), $urandom, e, "fault_hold");
    endtask

    // Runs one instruction from the expected plan. run_drop >= 0 forces Run
    // high before that cycle and low from it on; abort_at pulls Clear during
    // that cycle of the plan.
    task automatic run_instr(input logic [31:0] ir, input int stall, input logic run_end,
                             input int run_drop, input int abort_at, output bit faulted);
        step_t plan[$];
        step_t s;
        bit    legal, muldiv;
        logic  run;
        int    ra, rb, rc;

        legal  = ir_legal(ir);
        muldiv = MULDIV && (int'(ir[31:27]) > MAX_OPCODE);
        ra     = int'(ir[26:23]);
        rb     = int'(ir[22:19]);
        rc     = int'(ir[18:15]);

        if (in_idle) begin
            apply(1'b1, 1'($urandom), $urandom, quiet(), "idle_start");
            in_idle = 1'b0;
        end

        // Fetch: address out + PC increment, stall cycles, ready cycle, IR load.
        s = '{mem_ready: 1'($urandom), use_ir: 0, exp: quiet(), name: "fetch_addr"};
        s.exp.pc_out = 1; s.exp.mar_in = 1; s.exp.inc_pc = 1; s.exp.zlow_in = 1;
        plan.push_back(s);
        for (int k = 0; k < stall; k++) begin
            s = '{mem_ready: 1'b0, use_ir: 0, exp: quiet(), name: "fetch_stall"};
            s.exp.read = 1;
            plan.push_back(s);
        end
        s = '{mem_ready: 1'b1, use_ir: 0, exp: quiet(), name: "fetch_ready"};
        s.exp.read = 1; s.exp.zlow_out = 1; s.exp.pc_in = 1; s.exp.mdr_in = 1;
        plan.push_back(s);
        s = '{mem_ready: 1'($urandom), use_ir: 1, exp: quiet(), name: "fetch_ir"};
        s.exp.mdr_out = 1; s.exp.ir_in = 1;
        plan.push_back(s);

        // Execute.
        s = '{mem_ready: 1'($urandom), use_ir: 1, exp: quiet(), name: "exec_rb"};
        if (legal) begin
            s.exp.rout = reg_sel(rb); s.exp.y_in = 1;
        end
        plan.push_back(s);
        if (legal) begin
            s = '{mem_ready: 1'($urandom), use_ir: 1, exp: quiet(), name: "exec_alu"};
            s.exp.rout = reg_sel(rc); s.exp.op = ir[31:27]; s.exp.zlow_in = 1;
            s.exp.zhigh_in = muldiv;
            plan.push_back(s);
            s = '{mem_ready: 1'($urandom), use_ir: 1, exp: quiet(), name: "exec_wb"};
            s.exp.zlow_out = 1;
            if (muldiv) begin
                s.exp.lo_in = 1; s.exp.op = ir[31:27];
                plan.push_back(s);
                s = '{mem_ready: 1'($urandom), use_ir: 1, exp: quiet(), name: "exec_hi"};
                s.exp.zhigh_out = 1; s.exp.hi_in = 1; s.exp.done = 1; s.exp.op = ir[31:27];
            end else begin
                s.exp.rin = reg_sel(ra); s.exp.done = 1;
            end
            plan.push_back(s);
        end

        foreach (plan[j]) begin
            if (j == plan.size() - 1)  run = run_end;
            else if (run_drop >= 0)    run = (j < run_drop);
            else                       run = 1'($urandom);
            apply(run, plan[j].mem_ready, plan[j].use_ir ? ir : $urandom,
                  plan[j].exp, plan[j].name);
            if (j == abort_at) begin
                #1;
                bus.Run = 1'b0;
                Clear   = 1'b0;
                #1;
                model_count = '0;
                check("clear_abort", sample(), quiet());
                #1;
                Clear   = 1'b1;
                in_idle = 1'b1;
                faulted = 1'b0;
                return;
            end
        end

        faulted = !legal;
        if (legal) begin
            model_count = model_count + 1'b1;
            in_idle     = !run_end;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    vec_t        vecs[8];
    localparam logic [31:0] IR_ADD = 32'h2891_8000;   // op 5, Ra=1, Rb=2, Rc=3
    localparam logic [31:0] IR_MUL = 32'h6891_8000;   // op 13, Ra=1, Rb=2, Rc=3

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit          f;
        logic [31:0] ir;
        logic [4:0]  op;
        int          stall, abort_at;
        logic        run_end;

        // Directed first instruction from reset, fully spelled out.
        vecs[0] = '{1'b1, 1'b0, 32'h0, outs_t'{default: '0}, "idle_run"};
        vecs[1] = '{1'b1, 1'b0, 32'h0,
                    outs_t'{pc_out: 1'b1, mar_in: 1'b1, inc_pc: 1'b1, zlow_in: 1'b1, default: '0},
                    "t0"};
        vecs[2] = '{1'b1, 1'b1, 32'h0,
                    outs_t'{read: 1'b1, zlow_out: 1'b1, pc_in: 1'b1, mdr_in: 1'b1, default: '0},
                    "t1_ready"};
        vecs[3] = '{1'b1, 1'b0, IR_ADD,
                    outs_t'{mdr_out: 1'b1, ir_in: 1'b1, default: '0}, "t2"};
        vecs[4] = '{1'b1, 1'b0, IR_ADD,
                    outs_t'{rout: 16'h0004, y_in: 1'b1, default: '0}, "t3"};
        vecs[5] = '{1'b1, 1'b0, IR_ADD,
                    outs_t'{rout: 16'h0008, op: 5'b00101, zlow_in: 1'b1, default: '0}, "t4"};
        vecs[6] = '{1'b1, 1'b0, IR_ADD,
                    outs_t'{zlow_out: 1'b1, rin: 16'h0002, done: 1'b1, default: '0}, "t5"};
        vecs[7] = '{1'b1, 1'b0, IR_ADD,
                    outs_t'{pc_out: 1'b1, mar_in: 1'b1, inc_pc: 1'b1, zlow_in: 1'b1,
                            count: 16'd1, default: '0}, "t0_next"};

        Clear         = 1'b0;
        bus.Run       = 1'b1;
        bus.Mem_ready = 1'b1;
        bus.IR        = IR_ADD;
        model_count   = '0;
        in_idle       = 1'b1;
        repeat (2) @(negedge Clock);
        #1;
        check("reset_state", sample(), quiet());
        bus.Run = 1'b0;
        #1;
        Clear = 1'b1;

        for (int i = 0; i < 8; i++)
            apply(vecs[i].run, vecs[i].mem_ready, vecs[i].ir, vecs[i].exp, vecs[i].name);
        model_count = 16'd1;
        clear_pulse("clear_after_table");

        // Three-cycle memory stall: Read held across 4 cycles, 9-cycle instruction.
        run_instr(IR_ADD, 3, 1'b0, -1, -1, f);
        idle_hold(2);

        // Three back-to-back instructions, Run dropped during T3 of the third.
        clear_pulse("clear_before_burst");
        run_instr(IR_ADD, 0, 1'b1, -1, -1, f);
        run_instr(32'h0A4A_8000, 1, 1'b1, -1, -1, f);
        run_instr(32'h6000_0000 & 32'h07FF_FFFF | 32'h5BBB_8000, 0, 1'b0, 3, -1, f);
        idle_hold(3);

        // Illegal opcode 31: no T3 strobes, sticky Fault with Run high, Clear recovers.
        run_instr(32'hF800_0000, 0, 1'b1, -1, -1, f);
        if (f) fault_hold(4);
        clear_pulse("clear_from_fault");
        idle_hold(1);

        // Clear during T4 of the second instruction (count must return to 0).
        run_instr(IR_ADD, 0, 1'b1, -1, -1, f);
        run_instr(IR_ADD, 1, 1'b1, -1, 5, f);
        idle_hold(2);

        // Opcode 13: mul under ALU_MULDIV_EN, fault otherwise.
        run_instr(IR_MUL, 0, 1'b0, -1, -1, f);
        if (f) begin
            fault_hold(2);
            clear_pulse("clear_after_op13");
        end else begin
            idle_hold(1);
        end
        run_instr(IR_MUL + 32'h0800_0000, 1, 1'b0, -1, -1, f);   // opcode 14
        if (f) begin
            fault_hold(2);
            clear_pulse("clear_after_op14");
        end

        // Randomized instruction stream against the plan model.
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(13, 31))
                                              : 5'($urandom_range(0, 15));
            ir       = {op, 27'($urandom)};
            stall    = $urandom_range(0, 3);
            run_end  = ($urandom_range(0, 3) != 0);
            abort_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 5 + stall) : -1;
            run_instr(ir, stall, run_end, -1, abort_at, f);
            if (f) begin
                fault_hold($urandom_range(1, 3));
                clear_pulse("clear_random_fault");
            end else if (in_idle) begin
                idle_hold($urandom_range(0, 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
